// File: rtl/prim_pad_attr_pkg.sv
// Shared types, attribute bit positions and the WARL mask helper
// for the multi-pad attribute controller.
package prim_pad_attr_pkg;

   typedef enum logic [1:0] {
      PadBidir = 2'd0,
      PadInput = 2'd1,
      PadNone  = 2'd2
   } pad_type_e;

   typedef enum logic [1:0] {
      ApplyIdle   = 2'd0,
      ApplyPad    = 2'd1,
      ApplySettle = 2'd2,
      ApplyDone   = 2'd3
   } apply_state_e;

   localparam int unsigned AttrInvert    = 0;
   localparam int unsigned AttrVirtOdEn  = 1;
   localparam int unsigned AttrPullEn    = 2;
   localparam int unsigned AttrPullSel   = 3;
   localparam int unsigned AttrKeeperEn  = 4;
   localparam int unsigned AttrSchmittEn = 5;
   localparam int unsigned AttrOdEn      = 6;
   localparam int unsigned AttrSlewRate  = 7;
   localparam int unsigned AttrDriveLsb  = 8;
   localparam int unsigned AttrDriveMsb  = 11;
   localparam int unsigned AttrInDisable = 12;
   localparam int unsigned AttrCoreW     = 13;
   localparam int unsigned AttrMaxW      = 64;

   // Bits above the defined map are reserved and never writable.
   function automatic logic [AttrMaxW-1:0] warl_mask(
      input int unsigned pad_type,
      input int unsigned dw
   );
      logic [AttrMaxW-1:0] m;
      m = '0;
      if (pad_type == 32'(PadBidir)) begin
         m[AttrCoreW-1:0] = '1;
      end else if (pad_type == 32'(PadInput)) begin
         m[AttrInvert]    = 1'b1;
         m[AttrPullEn]    = 1'b1;
         m[AttrPullSel]   = 1'b1;
         m[AttrKeeperEn]  = 1'b1;
         m[AttrSchmittEn] = 1'b1;
         m[AttrInDisable] = 1'b1;
      end
      for (int i = 0; i < AttrMaxW; i++) begin
         if (i >= int'(dw)) m[i] = 1'b0;
      end
      return m;
   endfunction

endpackage

// File: rtl/prim_pad_attr_seq.sv
// Apply sequencer: walks the pads in order on commit, inserting a
// settle gap between consecutive pad updates.
module prim_pad_attr_seq
   import prim_pad_attr_pkg::*;
#(
   parameter int unsigned NumPads      = 4,
   parameter int unsigned SettleCycles = 2,
   parameter int unsigned IdxW         = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            commit,
   output logic            apply_en,
   output logic [IdxW-1:0] apply_idx,
   output logic            busy,
   output logic            done
);

   localparam int unsigned CntW =
      (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumPads - 1);
   localparam logic [CntW-1:0] CntInit = CntW'(SettleCycles - 1);

   apply_state_e    state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ApplyIdle;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      apply_en = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         ApplyIdle: begin
            if (commit) begin
               state_d = ApplyPad;
               idx_d   = '0;
            end
         end
         ApplyPad: begin
            apply_en = 1'b1;
            if (idx_q == LastIdx) begin
               state_d = ApplyDone;
            end else if (SettleCycles == 0) begin
               idx_d = idx_q + 1'b1;
            end else begin
               state_d = ApplySettle;
               cnt_d   = CntInit;
            end
         end
         ApplySettle: begin
            if (cnt_q == '0) begin
               state_d = ApplyPad;
               idx_d   = idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ApplyDone: begin
            done    = 1'b1;
            state_d = ApplyIdle;
         end
         default: state_d = ApplyIdle;
      endcase
   end

   assign apply_idx = idx_q;
   assign busy      = (state_q != ApplyIdle);

endmodule

// File: rtl/prim_pad_attr_ctrl.sv
// Multi-pad attribute controller: WARL shadow registers behind a
// req/gnt register port, applied to live outputs by the sequencer.
module prim_pad_attr_ctrl
   import prim_pad_attr_pkg::*;
#(
   parameter int unsigned NumPads          = 4,
   parameter int unsigned AttrDw           = 13,
   parameter int unsigned PadType          = 1,
   parameter int unsigned SettleCycles     = 2,
   parameter logic [AttrDw-1:0] ResetAttr  = '0,
   localparam int unsigned AddrW =
      (NumPads > 1) ? $clog2(NumPads) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      req_i,
   input  logic                      we_i,
   input  logic [AddrW-1:0]          addr_i,
   input  logic [AttrDw-1:0]         wdata_i,
   output logic                      gnt_o,
   output logic                      rvalid_o,
   output logic [AttrDw-1:0]         rdata_o,
   input  logic                      commit_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [NumPads*AttrDw-1:0] attr_o,
   output logic [AttrDw-1:0]         warl_mask_o
);

   localparam logic [AttrDw-1:0] Mask =
      AttrDw'(warl_mask(PadType, AttrDw));
   localparam logic [AttrDw-1:0] ResetVal = ResetAttr & Mask;
   localparam logic [AddrW:0] PadLimit = (AddrW + 1)'(NumPads);

   logic [AttrDw-1:0] shadow_q [NumPads];
   logic [AttrDw-1:0] live_q   [NumPads];
   logic [AttrDw-1:0] rd_word;
   logic [AttrDw-1:0] rdata_q;
   logic              rvalid_q;
   logic              gnt;
   logic              addr_ok;
   logic              wr_acc;
   logic              rd_acc;
   logic              apply_en;
   logic [AddrW-1:0]  apply_idx;
   logic              busy;
   logic              done;

   prim_pad_attr_seq #(
      .NumPads      (NumPads),
      .SettleCycles (SettleCycles),
      .IdxW         (AddrW)
   ) u_seq (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .commit    (commit_i),
      .apply_en  (apply_en),
      .apply_idx (apply_idx),
      .busy      (busy),
      .done      (done)
   );

   // The register port stalls for the whole apply sequence.
   assign gnt     = req_i & ~busy;
   assign addr_ok = ({1'b0, addr_i} < PadLimit);
   assign wr_acc  = gnt & we_i & addr_ok;
   assign rd_acc  = gnt & ~we_i;

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < int'(NumPads); k++) begin
         if (addr_ok && addr_i == AddrW'(k)) rd_word = shadow_q[k];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < int'(NumPads); k++) begin
            shadow_q[k] <= ResetVal;
            live_q[k]   <= ResetVal;
         end
      end else begin
         for (int k = 0; k < int'(NumPads); k++) begin
            if (wr_acc && addr_i == AddrW'(k)) begin
               shadow_q[k] <= wdata_i & Mask;
            end
            if (apply_en && apply_idx == AddrW'(k)) begin
               live_q[k] <= shadow_q[k];
            end
         end
      end
   end

   // rdata is cleared on every non-read cycle so it is 0 when idle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= rd_acc;
         rdata_q  <= rd_acc ? rd_word : '0;
      end
   end

   for (genvar k = 0; k < int'(NumPads); k++) begin : g_attr
      assign attr_o[k*AttrDw +: AttrDw] = live_q[k];
   end

   assign gnt_o       = gnt;
   assign rvalid_o    = rvalid_q;
   assign rdata_o     = rdata_q;
   assign busy_o      = busy;
   assign done_o      = done;
   assign warl_mask_o = Mask;

endmodule

// File: tb/tb_prim_pad_attr_ctrl.sv
// Directed vector bench for prim_pad_attr_ctrl: input-only 4-pad
// instance plus a 3-pad bidir instance with zero settle gap.
module tb_prim_pad_attr_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req = 1'b0, we = 1'b0, commit = 1'b0;
   logic [1:0]  addr = '0;
   logic [12:0] wdata = '0;
   logic        gnt, rvalid, busy, done;
   logic [12:0] rdata, mask;
   logic [51:0] attr;

   prim_pad_attr_ctrl #(
      .NumPads(4), .AttrDw(13), .PadType(1),
      .SettleCycles(2), .ResetAttr(13'h1FFF)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we),
      .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt),
      .rvalid_o(rvalid), .rdata_o(rdata), .commit_i(commit),
      .busy_o(busy), .done_o(done), .attr_o(attr),
      .warl_mask_o(mask)
   );

   logic        b_req = 1'b0, b_we = 1'b0, b_commit = 1'b0;
   logic [1:0]  b_addr = '0;
   logic [15:0] b_wdata = '0;
   logic        b_gnt, b_rvalid, b_busy, b_done;
   logic [15:0] b_rdata, b_mask;
   logic [47:0] b_attr;

   prim_pad_attr_ctrl #(
      .NumPads(3), .AttrDw(16), .PadType(0),
      .SettleCycles(0), .ResetAttr(16'h0000)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .we_i(b_we),
      .addr_i(b_addr), .wdata_i(b_wdata), .gnt_o(b_gnt),
      .rvalid_o(b_rvalid), .rdata_o(b_rdata), .commit_i(b_commit),
      .busy_o(b_busy), .done_o(b_done), .attr_o(b_attr),
      .warl_mask_o(b_mask)
   );

   typedef struct {
      logic        req, we;
      logic [1:0]  addr;
      logic [12:0] wdata;
      logic        commit;
      logic        gnt, rvalid;
      logic [12:0] rdata;
      logic        busy, done;
      logic [51:0] attr;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;
   vec_t vecs[$];

   localparam logic [12:0] R = 13'h103D;
   localparam logic [51:0] L0 = {R, R, R, R};
   localparam logic [51:0] L1 = {R, R, R, 13'h0004};
   localparam logic [51:0] L2 = {R, R, 13'h0008, 13'h0004};
   localparam logic [51:0] L3 = {R, 13'h0030, 13'h0008, 13'h0004};
   localparam logic [51:0] L4 = {13'h1020, 13'h0030, 13'h0008, 13'h0004};

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic r, w, input logic [1:0] a, input logic [12:0] d,
      input logic c, input logic g, rv, input logic [12:0] rd,
      input logic b, dn, input logic [51:0] at);
      vec_t v;
      v.req = r; v.we = w; v.addr = a; v.wdata = d; v.commit = c;
      v.gnt = g; v.rvalid = rv; v.rdata = rd;
      v.busy = b; v.done = dn; v.attr = at;
      return v;
   endfunction

   task automatic b_cyc(input logic r, w, input logic [1:0] a,
                        input logic [15:0] d, input logic c);
      b_req = r; b_we = w; b_addr = a; b_wdata = d; b_commit = c;
      @(posedge clk); #1;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_commit = 0;
   endtask

   initial begin
      logic seen;
      //            req we a  wdata    cm gnt rv rdata    bsy dn attr
      vecs.push_back(mk(1, 1, 2, 13'h1FFF, 0, 1, 0, 13'h0, 0, 0, L0));
      vecs.push_back(mk(1, 0, 2, 13'h0000, 0, 1, 1, R,     0, 0, L0));
      vecs.push_back(mk(1, 1, 2, 13'h0030, 0, 1, 0, 13'h0, 0, 0, L0));
      vecs.push_back(mk(1, 1, 0, 13'h0001, 0, 1, 0, 13'h0, 0, 0, L0));
      vecs.push_back(mk(1, 1, 1, 13'h0FC8, 0, 1, 0, 13'h0, 0, 0, L0));
      vecs.push_back(mk(1, 1, 3, 13'h1020, 0, 1, 0, 13'h0, 0, 0, L0));
      vecs.push_back(mk(1, 0, 1, 13'h0000, 0, 1, 1, 13'h8, 0, 0, L0));
      vecs.push_back(mk(1, 0, 0, 13'h0000, 0, 1, 1, 13'h1, 0, 0, L0));
      vecs.push_back(mk(1, 1, 0, 13'h0004, 1, 1, 0, 13'h0, 1, 0, L0));
      vecs.push_back(mk(1, 0, 2, 13'h0000, 0, 0, 0, 13'h0, 1, 0, L1));
      vecs.push_back(mk(1, 1, 2, 13'h0000, 1, 0, 0, 13'h0, 1, 0, L1));
      vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 0, 0, 13'h0, 1, 0, L1));
      vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 0, 0, 13'h0, 1, 0, L2));
      vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 0, 0, 13'h0, 1, 0, L2));
      vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 0, 0, 13'h0, 1, 0, L2));
      vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 0, 0, 13'h0, 1, 0, L3));
      vecs.push_back(mk(1, 0, 2, 13'h0000, 0, 0, 0, 13'h0, 1, 0, L3));
      vecs.push_back(mk(1, 0, 2, 13'h0000, 0, 0, 0, 13'h0, 1, 0, L3));
      vecs.push_back(mk(1, 0, 2, 13'h0000, 0, 0, 0, 13'h0, 1, 1, L4));
      vecs.push_back(mk(1, 0, 2, 13'h0000, 0, 0, 0, 13'h0, 0, 0, L4));
      vecs.push_back(mk(1, 0, 2, 13'h0000, 0, 1, 1, 13'h30, 0, 0, L4));
      vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 0, 0, 13'h0, 0, 0, L4));

      #12;
      chk("rst attr", attr, L0);
      chk("rst mask", mask, 13'h103D);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst rvalid", rvalid, 0);
      chk("rst rdata", rdata, 0);
      chk("rst b_attr", b_attr, 0);
      chk("rst b_mask", b_mask, 16'h1FFF);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         req = vecs[i].req; we = vecs[i].we; addr = vecs[i].addr;
         wdata = vecs[i].wdata; commit = vecs[i].commit;
         @(negedge clk);
         chk($sformatf("v%0d gnt", i), gnt, vecs[i].gnt);
         @(posedge clk); #1;
         chk($sformatf("v%0d rvalid", i), rvalid, vecs[i].rvalid);
         chk($sformatf("v%0d rdata", i), rdata, vecs[i].rdata);
         chk($sformatf("v%0d busy", i), busy, vecs[i].busy);
         chk($sformatf("v%0d done", i), done, vecs[i].done);
         chk($sformatf("v%0d attr", i), attr, vecs[i].attr);
      end
      req = 0; we = 0; addr = 0; wdata = 0; commit = 0;

      // Abort a sequence with reset after pad 1 has gone live.
      req = 1; we = 1; addr = 0; wdata = 13'h0021;
      @(posedge clk); #1;
      req = 0; we = 0; commit = 1;
      @(posedge clk); #1;
      commit = 0;
      repeat (4) @(posedge clk);
      #1;
      chk("abort pre attr", attr,
          {13'h1020, 13'h0030, 13'h0008, 13'h0021});
      chk("abort pre busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort attr", attr, L0);
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1'b1;
      end
      chk("abort no done", seen, 0);
      req = 1; we = 0; addr = 1;
      @(posedge clk); #1;
      req = 0;
      chk("abort shadow1 rvalid", rvalid, 1);
      chk("abort shadow1", rdata, R);
      req = 1; addr = 0;
      @(posedge clk); #1;
      req = 0;
      chk("abort shadow0", rdata, R);

      // Three-pad bidir instance, no settle gap, 16-bit words.
      b_cyc(1, 1, 0, 16'hFFFF, 0);
      b_cyc(1, 1, 1, 16'h0222, 0);
      b_cyc(1, 1, 2, 16'hE333, 0);
      b_cyc(1, 1, 3, 16'h0ABC, 0);
      chk("b wr rvalid", b_rvalid, 0);
      b_cyc(1, 0, 3, 16'h0000, 0);
      chk("b oob rvalid", b_rvalid, 1);
      chk("b oob rdata", b_rdata, 0);
      b_cyc(1, 0, 0, 16'h0000, 0);
      chk("b rd0", b_rdata, 16'h1FFF);
      b_cyc(1, 0, 2, 16'h0000, 0);
      chk("b rd2", b_rdata, 16'h0333);
      chk("b attr pre", b_attr, 0);
      b_cyc(0, 0, 0, 16'h0000, 1);
      chk("b e0 busy", b_busy, 1);
      chk("b e0 attr", b_attr, 0);
      b_cyc(0, 0, 0, 16'h0000, 0);
      chk("b e1 attr", b_attr, {16'h0, 16'h0, 16'h1FFF});
      b_cyc(0, 0, 0, 16'h0000, 0);
      chk("b e2 attr", b_attr, {16'h0, 16'h0222, 16'h1FFF});
      chk("b e2 done", b_done, 0);
      b_cyc(0, 0, 0, 16'h0000, 0);
      chk("b e3 attr", b_attr, {16'h0333, 16'h0222, 16'h1FFF});
      chk("b e3 done", b_done, 1);
      b_cyc(0, 0, 0, 16'h0000, 0);
      chk("b e4 busy", b_busy, 0);
      chk("b e4 done", b_done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
